// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path: state and operator
// encodings plus the display-select codes driven by calc_sequencer.
package calc_pkg;

  localparam int STATE_W = 3;
  localparam int OP_W    = 2;
  localparam int DISP_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_A      = 3'd0,
    ST_OP     = 3'd1,
    ST_B      = 3'd2,
    ST_EXEC   = 3'd3,
    ST_RESULT = 3'd4,
    ST_ERR    = 3'd5
  } calc_state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_t;

  localparam logic [DISP_W-1:0] DISP_SW  = 2'b00;
  localparam logic [DISP_W-1:0] DISP_RES = 2'b01;
  localparam logic [DISP_W-1:0] DISP_ERR = 2'b10;

  // The result view is selected as soon as EXEC is entered, so it shows the stale result until done.
  function automatic logic [DISP_W-1:0] disp_for(calc_state_t s);
    logic [DISP_W-1:0] d;
    case (s)
      ST_EXEC, ST_RESULT: d = DISP_RES;
      ST_ERR:             d = DISP_ERR;
      default:            d = DISP_SW;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Bundle between the sequencer and its datapath: operator switches, ALU handshake,
// operand load controls and display/status outputs.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic [OP_W-1:0]    op_in;
  logic               alu_done;
  logic               alu_err;
  logic               en_a;
  logic               a_src;
  logic               en_b;
  logic [OP_W-1:0]    op_code;
  logic               alu_start;
  logic [DISP_W-1:0]  disp_sel;
  logic [STATE_W-1:0] state_o;
  logic               busy;

  modport master (
    input  op_in, alu_done, alu_err,
    output en_a, a_src, en_b, op_code, alu_start, disp_sel, state_o, busy
  );

  modport slave (
    output op_in, alu_done, alu_err,
    input  en_a, a_src, en_b, op_code, alu_start, disp_sel, state_o, busy
  );

endinterface

// File: rtl/btn_conditioner.sv
// Raw pushbutton to one-cycle press pulse: two-flop synchroniser, consecutive-sample
// debounce, and a pulse on an accepted 0->1 change of the debounced level.
module btn_conditioner #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Counter tracks how many samples in a row disagreed with the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator entry FSM: A, operator, B, execute, result/error. Drives operand loads,
// operator latch, ALU start/done handshake with timeout, and the display selector.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enter_btn,
  input  logic                  clear_btn,
  calc_sequencer_if.master      bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic            enter_press;
  logic            clear_press;
  calc_state_t     state;
  calc_state_t     nxt_state;
  logic [TW-1:0]   cnt;
  logic [TW-1:0]   nxt_cnt;
  logic            nxt_en_a;
  logic            nxt_a_src;
  logic            nxt_en_b;
  logic            nxt_start;
  logic [OP_W-1:0] nxt_op;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (enter_btn),
    .press (enter_press)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (clear_btn),
    .press (clear_press)
  );

  // Next-state and next-output decode; clear overrides every enter-driven transition.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_en_a  = 1'b0;
    nxt_en_b  = 1'b0;
    nxt_start = 1'b0;
    nxt_a_src = bus.a_src;
    nxt_op    = bus.op_code;
    if (clear_press) begin
      nxt_state = ST_A;
    end else begin
      case (state)
        ST_A: begin
          if (enter_press) begin
            nxt_state = ST_OP;
            nxt_en_a  = 1'b1;
            nxt_a_src = 1'b0;
          end else begin
            nxt_state = ST_A;
          end
        end
        ST_OP: begin
          if (enter_press) begin
            nxt_state = ST_B;
            nxt_op    = bus.op_in;
          end else begin
            nxt_state = ST_OP;
          end
        end
        ST_B: begin
          if (enter_press) begin
            nxt_state = ST_EXEC;
            nxt_en_b  = 1'b1;
            nxt_start = 1'b1;
            nxt_cnt   = '0;
          end else begin
            nxt_state = ST_B;
          end
        end
        ST_EXEC: begin
          // A done arriving on the timeout cycle still counts as success.
          if (bus.alu_done) begin
            nxt_state = bus.alu_err ? ST_ERR : ST_RESULT;
          end else if (cnt == TO_LAST) begin
            nxt_state = ST_ERR;
          end else begin
            nxt_cnt = cnt + TW'(1);
          end
        end
        ST_RESULT: begin
          if (enter_press) begin
            nxt_state = ST_OP;
            nxt_en_a  = 1'b1;
            nxt_a_src = 1'b1;
          end else begin
            nxt_state = ST_RESULT;
          end
        end
        ST_ERR: begin
          if (enter_press) begin
            nxt_state = ST_A;
          end else begin
            nxt_state = ST_ERR;
          end
        end
        default: nxt_state = ST_A;
      endcase
    end
  end

  // State, counter and every output registered together so pulses line up with state changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_A;
      cnt           <= '0;
      bus.en_a      <= 1'b0;
      bus.a_src     <= 1'b0;
      bus.en_b      <= 1'b0;
      bus.op_code   <= 2'b00;
      bus.alu_start <= 1'b0;
      bus.disp_sel  <= DISP_SW;
      bus.busy      <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      bus.en_a      <= nxt_en_a;
      bus.a_src     <= nxt_a_src;
      bus.en_b      <= nxt_en_b;
      bus.op_code   <= nxt_op;
      bus.alu_start <= nxt_start;
      bus.disp_sel  <= disp_for(nxt_state);
      bus.busy      <= (nxt_state == ST_EXEC);
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: expected output events are queued as stimulus is
// applied and a monitor pops and compares them whenever the DUT changes state or pulses.
module tb_calc_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       en_a;
    logic       a_src;
    logic       en_b;
    logic       start;
    logic [1:0] op;
    logic [1:0] disp;
    logic       busy;
  } ev_t;

  logic clk;
  logic reset;
  logic enter_btn;
  logic clear_btn;

  int   errors;
  int   checks;
  ev_t  exp_q[$];
  logic m_a_src;
  logic [1:0] m_op;

  calc_sequencer_if bus();

  calc_sequencer #(.DB_CYCLES(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enter_btn (enter_btn),
    .clear_btn (clear_btn),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(logic [2:0] st, logic ea, logic eb, logic s);
    ev_t e;
    e.st    = st;
    e.en_a  = ea;
    e.a_src = m_a_src;
    e.en_b  = eb;
    e.start = s;
    e.op    = m_op;
    case (st)
      3'd3:    begin e.disp = 2'b01; e.busy = 1'b1; end
      3'd4:    begin e.disp = 2'b01; e.busy = 1'b0; end
      3'd5:    begin e.disp = 2'b10; e.busy = 1'b0; end
      default: begin e.disp = 2'b00; e.busy = 1'b0; end
    endcase
    return e;
  endfunction

  function automatic ev_t observe();
    ev_t e;
    e.st    = bus.state_o;
    e.en_a  = bus.en_a;
    e.a_src = bus.a_src;
    e.en_b  = bus.en_b;
    e.start = bus.alu_start;
    e.op    = bus.op_code;
    e.disp  = bus.disp_sel;
    e.busy  = bus.busy;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.state_o !== s && n < budget);
    chk(tag, {29'd0, bus.state_o}, {29'd0, s});
  endtask

  // Queue the expected event, hold enter until the target state appears, optionally release.
  task automatic press(input ev_t ev, input string tag, input bit release_btn);
    int n;
    exp_q.push_back(ev);
    enter_btn = 1'b1;
    wait_state(ev.st, 30, tag, n);
    if (release_btn) begin
      enter_btn = 1'b0;
      tick(8);
    end
  endtask

  task automatic chk_reset(input string tag);
    m_a_src = 1'b0;
    m_op    = 2'b00;
    chk(tag, {19'd0, observe()}, {19'd0, mk(3'd0, 1'b0, 1'b0, 1'b0)});
  endtask

  // Monitor: any state change or pulse must match the next queued expectation.
  initial begin
    logic [2:0] prev;
    ev_t obs;
    ev_t ex;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 3'd0;
      end else if (bus.state_o !== prev || bus.en_a || bus.en_b || bus.alu_start) begin
        obs = observe();
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_event: observed=%0h expected=none", obs);
        end
        if (exp_q.size() != 0) begin
          ex = exp_q.pop_front();
          chk("event", {19'd0, obs}, {19'd0, ex});
        end
        prev = bus.state_o;
      end
    end
  end

  initial begin
    int n;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    bus.op_in = 2'b00;
    bus.alu_done = 1'b0;
    bus.alu_err = 1'b0;
    m_a_src = 1'b0;
    m_op = 2'b00;
    tick(3);
    chk_reset("reset_values");
    reset = 1'b0;
    tick(3);
    chk_reset("after_reset");

    // Full sequence; raw edge to en_a should be 7 +/-1 edges (n counts one extra negedge).
    exp_q.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0));
    enter_btn = 1'b1;
    wait_state(3'd1, 20, "a_to_op", n);
    checks++;
    assert (n >= 7 && n <= 9) else begin
      errors++;
      $error("FAIL enter_latency: observed=%0d expected=8", n);
    end
    chk("en_a_pulse", {31'd0, bus.en_a}, 32'd1);
    tick(3);
    enter_btn = 1'b0;
    tick(8);

    bus.op_in = 2'b10;
    m_op = 2'b10;
    press(mk(3'd2, 1'b0, 1'b0, 1'b0), "op_to_b", 1'b1);
    chk("op_code_latched", {30'd0, bus.op_code}, 32'd2);

    press(mk(3'd3, 1'b0, 1'b1, 1'b1), "b_to_exec", 1'b0);
    chk("en_b_with_start", {30'd0, bus.en_b, bus.alu_start}, 32'd3);
    exp_q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0));
    tick(2);
    bus.alu_done = 1'b1;
    tick(1);
    bus.alu_done = 1'b0;
    enter_btn = 1'b0;
    wait_state(3'd4, 5, "exec_to_result", n);
    chk("result_disp", {30'd0, bus.disp_sel}, 32'd1);
    tick(8);

    // Chaining result into A.
    m_a_src = 1'b1;
    press(mk(3'd1, 1'b1, 1'b0, 1'b0), "chain_to_op", 1'b0);
    chk("chain_a_src", {29'd0, bus.en_a, bus.a_src, bus.alu_start}, 32'd6);
    enter_btn = 1'b0;
    tick(8);

    // ALU error path.
    bus.op_in = 2'b01;
    m_op = 2'b01;
    press(mk(3'd2, 1'b0, 1'b0, 1'b0), "op_to_b_2", 1'b1);
    press(mk(3'd3, 1'b0, 1'b1, 1'b1), "b_to_exec_2", 1'b0);
    enter_btn = 1'b0;
    exp_q.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0));
    tick(1);
    bus.alu_done = 1'b1;
    bus.alu_err = 1'b1;
    tick(1);
    bus.alu_done = 1'b0;
    bus.alu_err = 1'b0;
    wait_state(3'd5, 5, "alu_err_to_err", n);
    chk("err_disp", {30'd0, bus.disp_sel}, 32'd2);
    tick(8);
    press(mk(3'd0, 1'b0, 1'b0, 1'b0), "err_to_a", 1'b1);

    // Timeout: ERR exactly 16 cycles after alu_start.
    m_a_src = 1'b0;
    press(mk(3'd1, 1'b1, 1'b0, 1'b0), "a_to_op_3", 1'b1);
    bus.op_in = 2'b11;
    m_op = 2'b11;
    press(mk(3'd2, 1'b0, 1'b0, 1'b0), "op_to_b_3", 1'b1);
    press(mk(3'd3, 1'b0, 1'b1, 1'b1), "b_to_exec_3", 1'b0);
    enter_btn = 1'b0;
    exp_q.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0));
    wait_state(3'd5, 40, "timeout_to_err", n);
    chk("timeout_cycles", n, 32'd16);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
    clear_btn = 1'b1;
    wait_state(3'd0, 20, "clear_from_err", n);
    clear_btn = 1'b0;
    tick(8);

    // Clear and enter together in B: clear wins.
    press(mk(3'd1, 1'b1, 1'b0, 1'b0), "a_to_op_4", 1'b1);
    press(mk(3'd2, 1'b0, 1'b0, 1'b0), "op_to_b_4", 1'b1);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
    enter_btn = 1'b1;
    clear_btn = 1'b1;
    wait_state(3'd0, 20, "clear_beats_enter", n);
    chk("clear_no_start", {30'd0, bus.en_b, bus.alu_start}, 32'd0);
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    tick(10);

    // Clear in EXEC, then a late alu_done must be ignored.
    press(mk(3'd1, 1'b1, 1'b0, 1'b0), "a_to_op_5", 1'b1);
    press(mk(3'd2, 1'b0, 1'b0, 1'b0), "op_to_b_5", 1'b1);
    press(mk(3'd3, 1'b0, 1'b1, 1'b1), "b_to_exec_5", 1'b0);
    enter_btn = 1'b0;
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
    clear_btn = 1'b1;
    wait_state(3'd0, 20, "clear_in_exec", n);
    clear_btn = 1'b0;
    tick(2);
    bus.alu_done = 1'b1;
    tick(1);
    bus.alu_done = 1'b0;
    tick(10);
    chk("late_done_ignored", {29'd0, bus.state_o}, 32'd0);

    // Glitches shorter than the debounce window never produce a press.
    for (int g = 1; g <= 3; g++) begin
      enter_btn = 1'b1;
      tick(g);
      enter_btn = 1'b0;
      tick(10);
    end
    chk("glitch_no_press", {29'd0, bus.state_o}, 32'd0);

    // A long hold yields exactly one en_a.
    m_a_src = 1'b0;
    press(mk(3'd1, 1'b1, 1'b0, 1'b0), "hold_to_op", 1'b0);
    tick(42);
    enter_btn = 1'b0;
    tick(10);
    chk("hold_single_press", {29'd0, bus.state_o}, 32'd1);

    // Asynchronous reset mid-EXEC clears everything before the next edge.
    press(mk(3'd2, 1'b0, 1'b0, 1'b0), "op_to_b_6", 1'b1);
    press(mk(3'd3, 1'b0, 1'b1, 1'b1), "b_to_exec_6", 1'b0);
    enter_btn = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_reset("async_reset_exec");
    tick(3);
    reset = 1'b0;
    tick(12);
    chk("no_restart_after_reset", {29'd0, bus.state_o, bus.alu_start}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
